// File: rtl/load_store_unit_if.sv
// Request/response and word-memory signals of the load/store unit.
// slave = the LSU itself, master = execute stage plus data memory.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_w_dat;
  logic [2:0]        mem_dat_op;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_r_dat;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_r_dat,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_w_dat, mem_dat_op, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_r_dat,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_w_dat, mem_dat_op, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 byte/half/word load-store unit in front of a word-only data memory.
// Sub-word stores are done as read-modify-write; loads are sign/zero extended.
module load_store_unit #(
  parameter int ADDR_W        = 32,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    LWAIT  = 3'd2,
    MERGE  = 3'd3,
    RESP   = 3'd4,
    ERR    = 3'd5
  } state_e;

  state_e            state_q;
  logic              write_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic [15:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       w_dat_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic        illegal;
  logic        misaligned;
  logic [1:0]  lane_aln;
  logic        is_sw_q;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext_d;
  logic [31:0] merge_d;

  always_comb begin
    illegal    = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                 (bus.req_write && bus.req_funct3[2]);
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    // With trapping disabled the lane is forced to the natural alignment
    case (bus.req_funct3[1:0])
      2'b01:   lane_aln = {bus.req_addr[1], 1'b0};
      2'b10:   lane_aln = 2'b00;
      default: lane_aln = bus.req_addr[1:0];
    endcase
  end

  assign is_sw_q = write_q && (funct3_q[1:0] == 2'b10);

  always_comb begin
    byte_v = bus.mem_r_dat[{lane_q, 3'b000} +: 8];
    half_v = bus.mem_r_dat[{lane_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_ext_d = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_ext_d = {24'h0, byte_v};
      3'b001:  load_ext_d = {{16{half_v[15]}}, half_v};
      3'b101:  load_ext_d = {16'h0, half_v};
      default: load_ext_d = bus.mem_r_dat;
    endcase
    merge_d = bus.mem_r_dat;
    if (funct3_q[1:0] == 2'b00) merge_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else                        merge_d[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
      wdata_q    <= 16'h0;
      rdata_q    <= 32'h0;
      w_dat_q    <= 32'h0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          write_q    <= bus.req_write;
          funct3_q   <= bus.req_funct3;
          lane_q     <= lane_aln;
          wdata_q    <= bus.req_wdata[15:0];
          w_dat_q    <= bus.req_wdata;
          mem_addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
          if (illegal || (MISALIGN_TRAP && misaligned)) begin
            rdata_q <= 32'h0;
            state_q <= ERR;
          end else begin
            if (bus.req_write) rdata_q <= 32'h0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!write_q)     state_q <= LWAIT;
          else if (is_sw_q) state_q <= RESP;
          else              state_q <= MERGE;
        end
        LWAIT: begin
          rdata_q <= load_ext_d;
          state_q <= RESP;
        end
        MERGE: begin
          w_dat_q <= merge_d;
          state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes come straight from state so an async reset kills them immediately
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP) || (state_q == ERR);
    bus.resp_err   = (state_q == ERR);
    bus.resp_rdata = rdata_q;
    bus.mem_addr   = mem_addr_q;
    bus.mem_read   = (state_q == ACCESS) && !is_sw_q;
    bus.mem_write  = ((state_q == ACCESS) && is_sw_q) || (state_q == MERGE);
    bus.mem_dat_op = (bus.mem_read || bus.mem_write) ? 3'b010 : 3'b000;
    bus.mem_w_dat  = (state_q == MERGE) ? merge_d : w_dat_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a small word memory model.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) ifc ();

  load_store_unit #(.ADDR_W(32), .MISALIGN_TRAP(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic [31:0] mem [0:15];
  logic [31:0] r_dat = 32'h0;
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = 4'h0;
  logic [31:0] pre_dat = 32'h0;

  always @(posedge clk) begin
    if (ifc.mem_read)  r_dat <= mem[ifc.mem_addr[5:2]];
    if (ifc.mem_write) mem[ifc.mem_addr[5:2]] <= ifc.mem_w_dat;
    if (pre_we)        mem[pre_idx] <= pre_dat;
  end
  assign ifc.mem_r_dat = r_dat;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    longint      t_acc;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     strobe_cnt = 0;
  longint last_resp_t = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response is presented
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.mem_read && ifc.mem_write) check("rd_wr_exclusive", 32'd1, 32'd0);
      if (ifc.mem_read || ifc.mem_write) strobe_cnt++;
      if (ifc.resp_valid) begin
        last_resp_t = longint'($time);
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_err", {31'b0, ifc.resp_err}, {31'b0, e.err});
          check("resp_rdata", ifc.resp_rdata, e.rdata);
          check("latency", 32'(int'((longint'($time) - e.t_acc) / 10 + 1)), 32'(e.lat));
        end
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = 4'(idx); pre_dat = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic err, input logic [31:0] rd,
                        input int lat, input bit expect_resp, output longint t_acc);
    int n;
    exp_t e;
    @(negedge clk);
    ifc.req_valid = 1'b1; ifc.req_write = w; ifc.req_funct3 = f3;
    ifc.req_addr = a; ifc.req_wdata = wd;
    n = 0;
    while (!ifc.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    t_acc = 0;
    if (n >= 50) begin
      check("accept_timeout", 32'd1, 32'd0);
    end else begin
      @(posedge clk);
      t_acc = longint'($time);
      if (expect_resp) begin
        e.err = err; e.rdata = rd; e.lat = lat; e.t_acc = t_acc;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    ifc.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("resp_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t, t1;
    int     s0;
    ifc.req_valid = 1'b0; ifc.req_write = 1'b0; ifc.req_funct3 = 3'b000;
    ifc.req_addr = 32'h0; ifc.req_wdata = 32'h0;
    for (int i = 0; i < 16; i++) preload(i, 32'h0);
    #2;
    check("rst_req_ready", {31'b0, ifc.req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, ifc.resp_valid}, 32'd0);
    check("rst_mem_strobes", {30'b0, ifc.mem_read, ifc.mem_write}, 32'd0);
    check("rst_mem_addr", ifc.mem_addr, 32'h0);
    check("rst_mem_w_dat", ifc.mem_w_dat, 32'h0);
    check("rst_resp_rdata", ifc.resp_rdata, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Reset while the load waits for memory data
    preload(1, 32'h80FF1234);
    do_req(1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 32'h0, 0, 1'b0, t);
    @(posedge clk); #3;
    rst = 1'b1; ifc.req_valid = 1'b0;
    #1;
    check("t1_resp_valid", {31'b0, ifc.resp_valid}, 32'd0);
    check("t1_mem_read", {31'b0, ifc.mem_read}, 32'd0);
    check("t1_req_ready", {31'b0, ifc.req_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    // Loads with extension
    do_req(1'b0, 3'b000, 32'h7, 32'h0, 1'b0, 32'hFFFFFF80, 3, 1'b1, t);
    do_req(1'b0, 3'b100, 32'h7, 32'h0, 1'b0, 32'h00000080, 3, 1'b1, t);
    do_req(1'b0, 3'b001, 32'h6, 32'h0, 1'b0, 32'hFFFF80FF, 3, 1'b1, t);
    do_req(1'b0, 3'b101, 32'h6, 32'h0, 1'b0, 32'h000080FF, 3, 1'b1, t);
    do_req(1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 32'h80FF1234, 3, 1'b1, t);
    go_idle(); wait_done();

    // Stores, including read-modify-write
    preload(1, 32'h11223344);
    do_req(1'b1, 3'b000, 32'h5, 32'hDEADBEAA, 1'b0, 32'h0, 3, 1'b1, t);
    go_idle(); wait_done();
    check("t3_sb_mem", mem[1], 32'h1122AA44);
    do_req(1'b1, 3'b001, 32'h6, 32'h0000BEEF, 1'b0, 32'h0, 3, 1'b1, t);
    go_idle(); wait_done();
    check("t3_sh_mem", mem[1], 32'hBEEFAA44);
    do_req(1'b1, 3'b010, 32'h8, 32'hCAFEF00D, 1'b0, 32'h0, 2, 1'b1, t);
    go_idle(); wait_done();
    check("t3_sw_mem", mem[2], 32'hCAFEF00D);

    // Misaligned and illegal requests trap without touching memory
    s0 = strobe_cnt;
    do_req(1'b1, 3'b001, 32'h3, 32'h0000FFFF, 1'b1, 32'h0, 1, 1'b1, t);
    do_req(1'b0, 3'b010, 32'h2, 32'h0, 1'b1, 32'h0, 1, 1'b1, t);
    do_req(1'b0, 3'b011, 32'h4, 32'h0, 1'b1, 32'h0, 1, 1'b1, t);
    do_req(1'b1, 3'b100, 32'h4, 32'h000000FF, 1'b1, 32'h0, 1, 1'b1, t);
    go_idle(); wait_done();
    check("t4_no_strobes", 32'(strobe_cnt - s0), 32'd0);
    check("t4_mem1", mem[1], 32'hBEEFAA44);

    // Back-to-back: second request held while the first is busy
    preload(0, 32'h11223344);
    do_req(1'b1, 3'b000, 32'h0, 32'h00000055, 1'b0, 32'h0, 3, 1'b1, t);
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h11223355, 3, 1'b1, t1);
    check("t5_accept_gap", 32'(int'(t1 - last_resp_t)), 32'd15);
    go_idle(); wait_done();
    check("t5_mem0", mem[0], 32'h11223355);

    // Reset during the read phase of a byte store
    do_req(1'b1, 3'b000, 32'h1, 32'h000000EE, 1'b0, 32'h0, 0, 1'b0, t);
    #2;
    rst = 1'b1; ifc.req_valid = 1'b0;
    #1;
    check("t6_mem_read", {31'b0, ifc.mem_read}, 32'd0);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_mem0", mem[0], 32'h11223355);
    do_req(1'b0, 3'b100, 32'h1, 32'h0, 1'b0, 32'h00000033, 3, 1'b1, t);
    go_idle(); wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
